// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel LED sequencer (off/on/blink/burst) on a shared prescaled tick
//   Build option: define LED_DIM_EN to add the 4-bit dim input and a free-running PWM dimmer.
//   Ports:
//     clk      : single clock, rising edge
//     reset    : asynchronous, active-low, clears all state
//     dim      : (LED_DIM_EN only) brightness, 0 = dark, 15 = full
//     wr_en    : command write strobe
//     wr_ch    : target channel, values >= CH are ignored
//     wr_mode  : 0=OFF 1=ON 2=BLINK 3=BURST
//     wr_half  : half-period in ticks, 0 acts as 1
//     wr_count : BURST pulse count
//     tick     : one-cycle time-base pulse every PRESCALE cycles
//     led      : LED drive per channel
//     busy     : channel is running a burst
//     done     : one-cycle pulse when a burst completes
module led_sequencer #(
    parameter int CH = 4,
    parameter int PRESCALE = 10000000,
    parameter int HPW = 16,
    parameter int CW = 8,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
    localparam int PW = $clog2(PRESCALE)
) (
    input  logic           clk,
    input  logic           reset,
`ifdef LED_DIM_EN
    input  logic [3:0]     dim,
`endif
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [1:0]     wr_mode,
    input  logic [HPW-1:0] wr_half,
    input  logic [CW-1:0]  wr_count,
    output logic           tick,
    output logic [CH-1:0]  led,
    output logic [CH-1:0]  busy,
    output logic [CH-1:0]  done
);
    typedef enum logic [1:0] {OFF, ON, BLINK, BURST} mode_t;
    logic [PW-1:0] pre_cnt;
    logic [CH-1:0] led_q;
    assign tick = pre_cnt == PW'(PRESCALE - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) pre_cnt <= '0;
        else pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        mode_t m;
        logic [HPW-1:0] half, phase;
        logic [CW-1:0] rem;
        logic l, d;
        // a zero-count burst completes at the write itself
        logic empty_burst;
        assign empty_burst = wr_mode == BURST && wr_count == '0;
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                m <= OFF;
                half <= '0;
                phase <= '0;
                rem <= '0;
                l <= 1'b0;
                d <= 1'b0;
            end else if (wr_en && wr_ch == CHW'(i)) begin
                m <= empty_burst ? OFF : mode_t'(wr_mode);
                half <= (wr_half == '0) ? HPW'(1) : wr_half;
                rem <= wr_count;
                phase <= '0;
                l <= wr_mode != OFF && !empty_burst;
                d <= empty_burst;
            end else begin
                d <= 1'b0;
                if (tick && (m == BLINK || m == BURST)) begin
                    if (phase == half - HPW'(1)) begin
                        phase <= '0;
                        l <= ~l;
                        // only falling edges consume burst count
                        if (m == BURST && l) begin
                            rem <= rem - CW'(1);
                            if (rem == CW'(1)) begin
                                m <= OFF;
                                d <= 1'b1;
                            end
                        end
                    end else phase <= phase + HPW'(1);
                end
            end
        assign led_q[i] = l;
        assign done[i] = d;
        assign busy[i] = m == BURST;
    end
`ifdef LED_DIM_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 4'd1;
    assign led = led_q & {CH{dim == 4'd15 || pwm_cnt < dim}};
`else
    assign led = led_q;
`endif
endmodule
